// File: rtl/spm_pkg.sv
// Shared types and helpers for the scratchpad window controller: state encoding,
// word-geometry constants and the unsigned window-membership test.
package spm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_HIT_WAIT,
        ST_MISS_RD,
        ST_MISS_WR,
        ST_FLUSH,
        ST_DONE
    } spm_state_e;

    localparam int DEF_DATA_WID = 32;

    function automatic int word_bytes(input int data_wid);
        return data_wid / 8;
    endfunction

    function automatic int wb_log2(input int data_wid);
        return $clog2(data_wid / 8);
    endfunction

    // 65-bit compare so a window ending at the top of the address space cannot wrap.
    function automatic logic win_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len,
                                     input int          shift);
        logic [64:0] a;
        logic [64:0] lo;
        logic [64:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + ({1'b0, len} << shift);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/spm_ram.sv
// Single-port scratchpad RAM with registered read; read-before-write on a shared enable.
module spm_ram #(
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata
);

    logic [DATA_WID-1:0] mem_q [2**ADDR_WID];
    logic [DATA_WID-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spm_window_ctrl.sv
// Scratchpad window controller: fills a host window into SPM, serves kernel hits/misses,
// and writes the window back. Optional SPM_DIRTY_WB_EN limits write-back to dirty words.
module spm_window_ctrl
    import spm_pkg::*;
#(
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int SPM_LAT  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [63:0]         base_addr,
    input  logic [63:0]         num_words,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [63:0]         mem_addr,
    output logic [63:0]         mem_size,
    output logic [DATA_WID-1:0] mem_wdata,
    input  logic [DATA_WID-1:0] mem_rdata,
    input  logic                mem_rd_ready,
    input  logic                mem_wr_ready,
    output logic                finish_read,
    output logic                finish_write,
    input  logic                k_req,
    input  logic                k_we,
    input  logic [63:0]         k_addr,
    input  logic [DATA_WID-1:0] k_wdata,
    output logic                k_ack,
    output logic [DATA_WID-1:0] k_rdata,
    input  logic                k_done,
    output logic                k_run,
    output logic                done,
    output logic                busy,
    output logic [31:0]         miss_cnt
);

    localparam int DEPTH      = 2 ** ADDR_WID;
    localparam int LEN_W      = ADDR_WID + 1;
    localparam int WORD_BYTES = word_bytes(DATA_WID);
    localparam int WB_LOG2    = wb_log2(DATA_WID);
    localparam int LAT_W      = (SPM_LAT < 2) ? 1 : $clog2(SPM_LAT + 1);

    spm_state_e          state_q, state_d;
    logic [63:0]         base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;
    logic [ADDR_WID-1:0] req_idx_q, req_idx_d;
    logic                req_we_q, req_we_d;
    logic [DATA_WID-1:0] req_wdata_q, req_wdata_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [63:0]         mem_addr_q, mem_addr_d;
    logic [DATA_WID-1:0] mem_wdata_q, mem_wdata_d;
    logic                finish_read_q, finish_read_d;
    logic                finish_write_q, finish_write_d;
    logic                k_ack_q, k_ack_d;
    logic [DATA_WID-1:0] k_rdata_q, k_rdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                k_run_q, k_run_d;

    logic                ram_en;
    logic                ram_we;
    logic [ADDR_WID-1:0] ram_addr;
    logic [DATA_WID-1:0] ram_wdata;
    logic [DATA_WID-1:0] ram_rdata;

    logic [LEN_W-1:0]    start_len;
    logic [ADDR_WID-1:0] k_idx;
    logic [LEN_W-1:0]    idx_inc;
    logic [63:0]         inc_addr;
    logic                k_in_win;
    logic                last_beat;

    assign start_len = (num_words > 64'(DEPTH)) ? LEN_W'(DEPTH) : num_words[LEN_W-1:0];
    assign k_idx     = ADDR_WID'((k_addr - base_q) >> WB_LOG2);
    assign idx_inc   = idx_q + 1'b1;
    assign inc_addr  = base_q + (64'(idx_inc) << WB_LOG2);
    assign k_in_win  = win_hit(k_addr, base_q, 64'(len_q), WB_LOG2);
    assign last_beat = (idx_q == len_q - 1'b1);

`ifdef SPM_DIRTY_WB_EN
    logic             dirty_q [DEPTH];
    logic [LEN_W-1:0] scan_from;
    logic [LEN_W-1:0] scan_idx;
    logic             scan_found;
    logic [63:0]      scan_addr;

    // Lowest dirty index at or after scan_from inside the current window.
    assign scan_from = (state_q == ST_FLUSH) ? idx_inc : '0;
    assign scan_addr = base_q + (64'(scan_idx) << WB_LOG2);

    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (dirty_q[i] && (i >= int'(scan_from)) && (i < int'(len_q))) begin
                scan_found = 1'b1;
                scan_idx   = LEN_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && mem_rd_ready) begin
            dirty_q[idx_q[ADDR_WID-1:0]] <= 1'b0;
        end else if (state_q == ST_HIT_WAIT && lat_q == '0 && req_we_q) begin
            dirty_q[req_idx_q] <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        len_d          = len_q;
        idx_d          = idx_q;
        lat_d          = lat_q;
        miss_cnt_d     = miss_cnt_q;
        req_idx_d      = req_idx_q;
        req_we_d       = req_we_q;
        req_wdata_d    = req_wdata_q;
        mem_rd_en_d    = mem_rd_en_q;
        mem_wr_en_d    = mem_wr_en_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        finish_read_d  = 1'b0;
        finish_write_d = 1'b0;
        k_ack_d        = 1'b0;
        k_rdata_d      = k_rdata_q;
        done_d         = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = idx_q[ADDR_WID-1:0];
        ram_wdata      = mem_rdata;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (start_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        base_d      = base_addr;
                        len_d       = start_len;
                        idx_d       = '0;
                        miss_cnt_d  = '0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                        state_d     = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (mem_rd_ready) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    if (last_beat) begin
                        mem_rd_en_d = 1'b0;
                        mem_addr_d  = '0;
                        state_d     = ST_RUN;
                    end else begin
                        idx_d         = idx_inc;
                        mem_addr_d    = inc_addr;
                        finish_read_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // While k_ack is high the kernel is still holding the request it just completed.
                if (k_req && !k_ack_q) begin
                    if (k_in_win) begin
                        req_idx_d   = k_idx;
                        req_we_d    = k_we;
                        req_wdata_d = k_wdata;
                        ram_en      = !k_we;
                        ram_addr    = k_idx;
                        lat_d       = LAT_W'(SPM_LAT);
                        state_d     = ST_HIT_WAIT;
                    end else begin
                        mem_addr_d  = k_addr;
                        mem_wdata_d = k_wdata;
                        if (k_we) begin
                            mem_wr_en_d = 1'b1;
                            state_d     = ST_MISS_WR;
                        end else begin
                            mem_rd_en_d = 1'b1;
                            state_d     = ST_MISS_RD;
                        end
                    end
                end else if (k_done) begin
                    state_d = ST_FLUSH;
`ifdef SPM_DIRTY_WB_EN
                    if (scan_found) begin
                        idx_d       = scan_idx;
                        mem_wr_en_d = 1'b1;
                        mem_addr_d  = scan_addr;
                        ram_en      = 1'b1;
                        ram_addr    = scan_idx[ADDR_WID-1:0];
                    end
`else
                    idx_d       = '0;
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = base_q;
                    ram_en      = 1'b1;
                    ram_addr    = '0;
`endif
                end
            end
            ST_HIT_WAIT: begin
                if (lat_q == '0) begin
                    k_ack_d = 1'b1;
                    state_d = ST_RUN;
                    if (req_we_q) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = req_idx_q;
                        ram_wdata = req_wdata_q;
                    end else begin
                        k_rdata_d = ram_rdata;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_MISS_RD: begin
                if (mem_rd_ready) begin
                    mem_rd_en_d = 1'b0;
                    mem_addr_d  = '0;
                    k_ack_d     = 1'b1;
                    k_rdata_d   = mem_rdata;
                    miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_MISS_WR: begin
                if (mem_wr_ready) begin
                    mem_wr_en_d = 1'b0;
                    mem_addr_d  = '0;
                    k_ack_d     = 1'b1;
                    miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The RAM read for the next beat is issued alongside the accepted beat,
                // so ram_rdata always holds the word currently on mem_wdata.
`ifdef SPM_DIRTY_WB_EN
                if (!mem_wr_en_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (mem_wr_ready) begin
                    if (scan_found) begin
                        idx_d          = scan_idx;
                        mem_addr_d     = scan_addr;
                        ram_en         = 1'b1;
                        ram_addr       = scan_idx[ADDR_WID-1:0];
                        finish_write_d = 1'b1;
                    end else begin
                        mem_wr_en_d = 1'b0;
                        mem_addr_d  = '0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
`else
                if (mem_wr_ready) begin
                    if (last_beat) begin
                        mem_wr_en_d = 1'b0;
                        mem_addr_d  = '0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        idx_d          = idx_inc;
                        mem_addr_d     = inc_addr;
                        ram_en         = 1'b1;
                        ram_addr       = idx_inc[ADDR_WID-1:0];
                        finish_write_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = !(state_d inside {ST_IDLE, ST_DONE});
        k_run_d = state_d inside {ST_RUN, ST_MISS_RD, ST_MISS_WR};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            lat_q          <= '0;
            miss_cnt_q     <= '0;
            req_idx_q      <= '0;
            req_we_q       <= 1'b0;
            req_wdata_q    <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            k_ack_q        <= 1'b0;
            k_rdata_q      <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            k_run_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            lat_q          <= lat_d;
            miss_cnt_q     <= miss_cnt_d;
            req_idx_q      <= req_idx_d;
            req_we_q       <= req_we_d;
            req_wdata_q    <= req_wdata_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            finish_read_q  <= finish_read_d;
            finish_write_q <= finish_write_d;
            k_ack_q        <= k_ack_d;
            k_rdata_q      <= k_rdata_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            k_run_q        <= k_run_d;
        end
    end

    spm_ram #(
        .ADDR_WID(ADDR_WID),
        .DATA_WID(DATA_WID)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_size     = (mem_rd_en_q || mem_wr_en_q) ? 64'(WORD_BYTES) : 64'd0;
    assign mem_wdata    = (state_q == ST_FLUSH) ? ram_rdata : mem_wdata_q;
    assign finish_read  = finish_read_q;
    assign finish_write = finish_write_q;
    assign k_ack        = k_ack_q;
    assign k_rdata      = k_rdata_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign k_run        = k_run_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_spm_window_ctrl.sv
// Directed bench for spm_window_ctrl with a host-memory responder and write/read scoreboards.
module tb_spm_window_ctrl;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   base_addr = '0;
    logic [63:0]   num_words = '0;
    logic          mem_rd_en, mem_wr_en;
    logic [63:0]   mem_addr, mem_size;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rd_ready = 1'b0;
    logic          mem_wr_ready = 1'b0;
    logic          finish_read, finish_write;
    logic          k_req = 1'b0, k_we = 1'b0, k_done = 1'b0;
    logic [63:0]   k_addr = '0;
    logic [DW-1:0] k_wdata = '0;
    logic          k_ack, k_run, done, busy;
    logic [DW-1:0] k_rdata;
    logic [31:0]   miss_cnt;

    always #5 clk = ~clk;

    spm_window_ctrl #(.ADDR_WID(AW), .DATA_WID(DW), .SPM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_words(num_words),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready),
        .mem_wr_ready(mem_wr_ready), .finish_read(finish_read), .finish_write(finish_write),
        .k_req(k_req), .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata), .k_ack(k_ack),
        .k_rdata(k_rdata), .k_done(k_done), .k_run(k_run), .done(done), .busy(busy),
        .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic [63:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    int checks = 0, passes = 0, fails = 0;
    logic [DW-1:0] hostmem [logic [63:0]];
    wr_t           exp_wr [$];
    logic [DW-1:0] exp_rd [$];
    int rdy_mode = 0;
    int rd_beats = 0, wr_beats = 0, fr_pulses = 0, fw_pulses = 0, done_pulses = 0;
    int en_cycles = 0, unexp_wr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit go();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 1) return ($urandom_range(0, 2) != 0);
        return 1'b0;
    endfunction

    // Host memory responder and pulse monitor; write beats are scored here.
    always @(negedge clk) begin
        mem_rd_ready = 1'b0;
        mem_wr_ready = 1'b0;
        if (mem_rd_en || mem_wr_en) en_cycles++;
        if (finish_read)  fr_pulses++;
        if (finish_write) fw_pulses++;
        if (done)         done_pulses++;
        if (mem_rd_en && go()) begin
            mem_rd_ready = 1'b1;
            mem_rdata = hostmem.exists(mem_addr) ? hostmem[mem_addr] : 32'hDEAD_0000;
            rd_beats++;
        end
        if (mem_wr_en && go()) begin
            wr_t e;
            mem_wr_ready = 1'b1;
            wr_beats++;
            if (exp_wr.size() == 0) begin
                unexp_wr++;
                $display("unexpected host write addr=0x%0h data=%0d", mem_addr, mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
                $display("host write addr=0x%0h data=%0d", mem_addr, mem_wdata);
            end
            hostmem[mem_addr] = mem_wdata;
        end
    end

    task automatic do_start(input logic [63:0] b, input logic [63:0] nw, output int n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_words = nw; n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (!(k_run || done) && n < 500);
        $display("start base=0x%0h num_words=%0d -> %0d cycles", b, nw, n);
    endtask

    task automatic kacc(input logic we, input logic [63:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_data, output int lat);
        logic [DW-1:0] e;
        if (!we) exp_rd.push_back(exp_data);
        @(posedge clk); #1;
        k_req = 1'b1; k_we = we; k_addr = a; k_wdata = wd; lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!k_ack && lat < 200);
        chk("k_ack_seen", 64'(k_ack), 64'd1);
        if (!we && exp_rd.size() != 0) begin
            e = exp_rd.pop_front();
            chk("k_rdata", 64'(k_rdata), 64'(e));
        end
        $display("kernel %s addr=0x%0h wdata=%0d rdata=%0d latency=%0d",
                 we ? "write" : "read", a, wd, k_rdata, lat);
        @(posedge clk); #1;
        k_req = 1'b0; k_we = 1'b0;
    endtask

    task automatic do_flush(output int n);
        @(posedge clk); #1;
        k_done = 1'b1; n = 0;
        do begin
            @(posedge clk); #1;
            k_done = 1'b0;
            n++;
        end while (!done && n < 500);
        $display("flush -> done after %0d cycles", n);
    endtask

    initial begin
        int n, lat, d0, fr0, fw0, en0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_mem_size", mem_size, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_k_run", 64'(k_run), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        reset_n = 1'b1;

        // Job 1: base 0x1000, 4 words
        for (int i = 0; i < 4; i++) hostmem[64'h1000 + 64'(4 * i)] = 32'(10 + i);
        rdy_mode = 0; fr0 = fr_pulses;
        do_start(64'h1000, 64'd4, n);
        chk("fill_cycles", 64'(n), 64'd5);
        chk("fill_beats", 64'(rd_beats), 64'd4);
        chk("fill_finish_read", 64'(fr_pulses - fr0), 64'd3);
        chk("run_k_run", 64'(k_run), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_rd_en_low", 64'(mem_rd_en), 64'd0);

        kacc(1'b0, 64'h1008, '0, 32'd12, lat);
        chk("hit_rd_latency", 64'(lat), 64'(LAT + 2));
        kacc(1'b0, 64'h1000, '0, 32'd10, lat);
        kacc(1'b1, 64'h1004, 32'd99, '0, lat);
        chk("hit_wr_latency", 64'(lat), 64'(LAT + 2));
        kacc(1'b0, 64'h1005, '0, 32'd99, lat);

        // Forwarded accesses just outside the window
        hostmem[64'h0FFC] = 32'h0ABC;
        kacc(1'b0, 64'h0FFC, '0, 32'h0ABC, lat);
        chk("miss_rd_latency", 64'(lat), 64'd2);
        exp_wr.push_back('{addr: 64'h1010, data: 32'd77});
        rdy_mode = 1;
        kacc(1'b1, 64'h1010, 32'd77, '0, lat);
        chk("miss_cnt_2", 64'(miss_cnt), 64'd2);
        kacc(1'b0, 64'h100C, '0, 32'd13, lat);

        // Write-back
        fw0 = fw_pulses; d0 = done_pulses;
`ifdef SPM_DIRTY_WB_EN
        exp_wr.push_back('{addr: 64'h1004, data: 32'd99});
`else
        exp_wr.push_back('{addr: 64'h1000, data: 32'd10});
        exp_wr.push_back('{addr: 64'h1004, data: 32'd99});
        exp_wr.push_back('{addr: 64'h1008, data: 32'd12});
        exp_wr.push_back('{addr: 64'h100C, data: 32'd13});
`endif
        do_flush(n);
        chk("flush_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("flush_all_written", 64'(exp_wr.size()), 64'd0);
        chk("no_unexpected_wr", 64'(unexp_wr), 64'd0);
        chk("done_pulse_count", 64'(done_pulses - d0), 64'd1);
`ifdef SPM_DIRTY_WB_EN
        chk("flush_finish_write", 64'(fw_pulses - fw0), 64'd0);
`else
        chk("flush_finish_write", 64'(fw_pulses - fw0), 64'd3);
`endif

        // Zero-length job
        rdy_mode = 0; en0 = en_cycles; d0 = done_pulses;
        do_start(64'h5000, 64'd0, n);
        chk("zero_done_latency", 64'(n), 64'd1);
        chk("zero_done", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_no_traffic", 64'(en_cycles - en0), 64'd0);
        chk("zero_done_pulses", 64'(done_pulses - d0), 64'd1);

        // Oversized job: only DEPTH words cached
        for (int i = 0; i < 6; i++) hostmem[64'h2000 + 64'(4 * i)] = 32'(100 + i);
        rd_beats = 0;
        do_start(64'h2000, 64'd6, n);
        chk("clamp_fill_beats", 64'(rd_beats), 64'd4);
        kacc(1'b0, 64'h2014, '0, 32'd105, lat);
        chk("clamp_miss_lat", 64'(lat), 64'd2);
        chk("clamp_miss_cnt", 64'(miss_cnt), 64'd1);
        kacc(1'b0, 64'h200C, '0, 32'd103, lat);
        chk("clamp_hit_lat", 64'(lat), 64'(LAT + 2));
`ifndef SPM_DIRTY_WB_EN
        for (int i = 0; i < 4; i++)
            exp_wr.push_back('{addr: 64'h2000 + 64'(4 * i), data: 32'(100 + i)});
`endif
        do_flush(n);
`ifdef SPM_DIRTY_WB_EN
        chk("clamp_flush_cycles", 64'(n), 64'd2);
`else
        chk("clamp_flush_cycles", 64'(n), 64'd5);
`endif
        chk("clamp_flush_written", 64'(exp_wr.size()), 64'd0);

        // Reset during a stalled fill
        rdy_mode = 2;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 64'h3000; num_words = 64'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_rd_en", 64'(mem_rd_en), 64'd1);
        chk("stall_mem_size", mem_size, 64'd4);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
        chk("abort_mem_addr", mem_addr, 64'd0);
        chk("abort_mem_size", mem_size, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_fr", 64'(finish_read), 64'd0);
        reset_n = 1'b1;
        rdy_mode = 0;
        hostmem[64'h3000] = 32'd7;
        hostmem[64'h3004] = 32'd8;
        do_start(64'h3000, 64'd2, n);
        chk("refill_cycles", 64'(n), 64'd3);
        chk("refill_miss_cnt", 64'(miss_cnt), 64'd0);
        kacc(1'b0, 64'h3004, '0, 32'd8, lat);
        kacc(1'b0, 64'h3000, '0, 32'd7, lat);
`ifndef SPM_DIRTY_WB_EN
        exp_wr.push_back('{addr: 64'h3000, data: 32'd7});
        exp_wr.push_back('{addr: 64'h3004, data: 32'd8});
`endif
        do_flush(n);
        chk("refill_flush_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("refill_flush_written", 64'(exp_wr.size()), 64'd0);
        chk("final_unexpected_wr", 64'(unexp_wr), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spm_window_ctrl.md
# spm_window_ctrl

Parametrised scratchpad window controller between an accelerator kernel and the host memory bridge. On `start` it preloads a window of up to 2^ADDR_WID words from host memory into on-chip SPM. It then serves kernel reads and writes: in-window accesses hit the SPM with a configurable latency, and out-of-window accesses are forwarded to host memory. On kernel completion it writes the window back. It succeeds the fixed 8192×32 controller, adding explicit handshakes, a parametrised geometry, a zero-length start path and a miss counter.

## Interface
- `ADDR_WID`, 13: SPM index width; DEPTH = 2^ADDR_WID words.
- `DATA_WID`, 32: word width, multiple of 8; WORD_BYTES = DATA_WID/8.
- `SPM_LAT`, 5: extra hit cycles, ≥0.
- `clk` in 1: single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a job; sampled in IDLE/DONE only.
- `base_addr` in 64: byte address of window, word aligned.
- `num_words` in 64: job length in words.
- `mem_rd_en` out 1: host read request, level held.
- `mem_wr_en` out 1: host write request, level held.
- `mem_addr` out 64: host byte address.
- `mem_size` out 64: constant WORD_BYTES while a request is active, else 0.
- `mem_wdata` out DATA_WID: host write data.
- `mem_rdata` in DATA_WID: host read data.
- `mem_rd_ready` in 1: read beat accepted/data valid.
- `mem_wr_ready` in 1: write beat accepted.
- `finish_read`, `finish_write` out 1: one-cycle beat-done pulse for every non-final burst beat.
- `k_req`, `k_we` in 1: kernel request and write flag; held until `k_ack`.
- `k_addr` in 64: kernel byte address.
- `k_wdata` in DATA_WID: kernel write data.
- `k_ack` out 1: one-cycle completion pulse.
- `k_rdata` out DATA_WID: read data, valid with `k_ack`.
- `k_done` in 1: kernel finished.
- `k_run` out 1: kernel may run (high in RUN/MISS states).
- `done` out 1: one-cycle pulse at job end.
- `busy` out 1: state ≠ IDLE/DONE.
- `miss_cnt` out 32: forwarded accesses this job, saturating.

## Operation
- States: IDLE, FILL, RUN, HIT_WAIT, MISS_RD, MISS_WR, FLUSH, DONE.
- IDLE/DONE + `start` behaves as follows:
  - LEN = min(`num_words`, DEPTH).
  - If LEN = 0, go to DONE and pulse `done` with no memory traffic.
  - Otherwise latch base and LEN, clear `miss_cnt`, and go to FILL.
- FILL:
  - `mem_rd_en` is held with `mem_addr` = base + i·WORD_BYTES.
  - Each `mem_rd_ready` stores `mem_rdata` at index i.
  - After the LEN-th beat, drop `mem_rd_en` and go to RUN.
- RUN: window = [base, base + LEN·WORD_BYTES), compared unsigned in 65 bits. Index = (k_addr − base) >> log2(WORD_BYTES); low address bits are ignored.
- Hit → HIT_WAIT:
  - `k_ack` fires SPM_LAT+1 cycles after the request is sampled.
  - A write commits to the SPM on the ack cycle.
- Miss → MISS_RD/MISS_WR:
  - Drive `mem_rd_en`/`mem_wr_en` with `k_addr` (and `k_wdata` for writes) until the ready input is seen.
  - Pulse `k_ack` on the next cycle with `k_rdata` = captured `mem_rdata`.
  - Increment `miss_cnt`.
- `k_done` in RUN with no request in flight → FLUSH. If `k_req` and `k_done` are high together, the request is served first.
- FLUSH writes indices 0..LEN−1 to base + i·WORD_BYTES with `mem_wr_en` held. After the last `mem_wr_ready`, go to DONE and pulse `done`.
- `start` while `busy` is ignored.
- `num_words` > DEPTH: only DEPTH words are cached; the rest miss.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0. SPM contents undefined.
- Reset mid-job aborts any host handshake the next cycle. Enables drop with no pulse.
- Hit latency is SPM_LAT+2 cycles from `k_req` rising to `k_ack`. `k_req` must drop the cycle after `k_ack`.
- Burst throughput is 1 word/cycle when ready is held high.
- `finish_*` pulses the cycle after each non-final ready.
- `done` is high exactly one cycle, then the block rests in DONE.

## Configuration
- `SPM_DIRTY_WB_EN` defined:
  - Per-word dirty bit, cleared during FILL and set on kernel write hits.
  - FLUSH skips clean words, and `mem_addr` jumps to the next dirty index.
  - If no word is dirty, go FLUSH→DONE in one cycle.
- Undefined: FLUSH writes all LEN words.

## Structure
- `spm_pkg`: state enum, WORD_BYTES/log2 constants, `win_hit` function.
- Sub-module `spm_ram`: single-port DEPTH×DATA_WID RAM with registered read and write enable; dirty bits stay in the controller.

## Test plan
- base=0x1000, num_words=4, host data 10,11,12,13, kernel reads 0x1008 → FILL of 4 beats, `k_ack` 7 cycles after `k_req` with `k_rdata`=12.
- Kernel writes 99 to 0x1004, then `k_done` → FLUSH writes 10,99,12,13 to 0x1000..0x100C, then one `done` pulse. With `SPM_DIRTY_WB_EN`: a single write of 99 to 0x1004.
- Kernel read at 0x0FFC and write at 0x1010 → forwarded to host; `miss_cnt`=2; SPM untouched.
- num_words=0 → `done` 1 cycle after `start`; `mem_rd_en`/`mem_wr_en` never assert.
- ADDR_WID=2, num_words=6 → fill 4 words; access to word 5 misses; flush writes 4 words.
- `reset_n` low mid-FILL with `mem_rd_ready` stalled → next cycle all outputs 0 and state IDLE; a new `start` refills correctly.
